axi_line_engine: RTL and testbench
==================================

Name: axi_line_engine

Overview:
- Parametrised cache-line transfer engine between the data cache and the DDR AXI master port; successor to the fixed 128-bit single-transfer path.
- Per request: optional dirty-line writeback burst (AW/W/B), then line-fill burst (AR/R), then one-cycle response to the cache.
- One request outstanding at a time; the cache stalls (cache_nstall low) while busy is high.

Parameters:
- ADDR_W, 27, AXI byte-address width
- DATA_W, 128, AXI data width (power of 2, >=32)
- BEATS, 4, beats per cache line (power of 2, 1..16)
- LINE_W, DATA_W*BEATS, derived line width; not overridable

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  cache request
- req_ready  out  1  engine idle, accepts request
- req_wb  in  1  writeback victim before fill
- req_wb_addr  in  ADDR_W  victim line address (line aligned)
- req_fill_addr  in  ADDR_W  fill line address (line aligned)
- req_wdata  in  LINE_W  victim line, beat 0 in LSBs
- resp_valid  out  1  one-cycle pulse, fill complete
- resp_rdata  out  LINE_W  filled line, beat 0 in LSBs
- resp_err  out  1  any BRESP/RRESP non-OKAY this request (valid with resp_valid)
- busy  out  1  not IDLE
- m_axi_awaddr/awlen/awvalid/awready  out/out/out/in  ADDR_W/8/1/1  write address
- m_axi_wdata/wstrb/wlast/wvalid/wready  out/out/out/out/in  DATA_W/DATA_W/8/1/1/1  write data
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response
- m_axi_araddr/arlen/arvalid/arready  out/out/out/in  ADDR_W/8/1/1  read address
- m_axi_rdata/rresp/rlast/rvalid/rready  in/in/in/in/out  DATA_W/2/1/1/1  read data

Behaviour:
- Reset: all valid/ready-to-AXI outputs 0; req_ready 1; resp_valid 0; resp_err 0; resp_rdata 0; beat counter 0; state IDLE.
- Handshake: transfer on valid && ready at the rising edge. Once asserted, a valid is held with stable payload until accepted.
- IDLE: req_ready=1. On req_valid, latch addresses and req_wdata, clear error flag, go to WADDR if req_wb else RADDR.
- WADDR: awvalid and wvalid asserted together (awlen=BEATS-1, wstrb all ones). AW and W may complete in either order; track aw_done. Beat counter advances per W handshake. wlast=1 when counter==BEATS-1. When aw_done and last beat accepted, go to WRESP.
- WRESP: bready=1. On bvalid, OR (bresp!=0) into error flag, go to RADDR.
- RADDR: arvalid=1, arlen=BEATS-1. On arready, go to RDATA with counter 0.
- RDATA: rready=1. Each beat is stored to line slot [counter]; rresp error is ORed in; counter increments.
  - rlast on the final beat, or counter==BEATS-1, ends the burst. Mismatch between rlast and the count sets the error flag. Go to RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_rdata held until the next request is accepted; return to IDLE. Earliest next req acceptance is the following cycle.
- Latency with zero-wait slave, BEATS=4, no writeback: req accept -> resp_valid in 7 cycles (RADDR 1, RDATA 4, RESP 1, +1 register).
- Errors never abort the sequence; the fill always completes.
- Reset mid-burst: immediate return to IDLE, outputs to reset values. The interconnect is reset by the same rst, so there is no drain.
- BEATS=1: wlast is asserted on the only beat.

Optional Feature:
- AXI_TIMEOUT_EN defined: 16-bit watchdog counts cycles in WRESP or RDATA with no handshake progress; reaching 0xFFFF sets resp_err, forces resp_valid, and returns to IDLE.
- Undefined: no watchdog; the engine waits indefinitely.

Decomposition:
- Package axi_line_pkg: state enum, AXI_RESP_OKAY=2'b00, fixed field constants (AWSIZE=$clog2(DATA_W/8), BURST_INCR=2'b01, CACHE=4'b0011, PROT=0, QOS=0), driven onto the constant AXI ports in top.
- No sub-module needed. Optional: axi_line_beat_mux (line<->beat select) if reused by an instruction-side engine.

Test Plan:
- Fill only, BEATS=4, addr 0x0000100, slave returns beats 0xA..0xD -> arlen=3, one resp_valid pulse, resp_rdata = {0xD,0xC,0xB,0xA}, resp_err=0.
- Writeback + fill, victim 0x0000200, fill 0x0000300, with awready delayed 5 cycles after wready -> 4 W beats, wlast only on the 4th, AR issued only after bvalid, data correct.
- bresp=SLVERR on writeback -> fill still performed; resp_err=1 with resp_valid.
- rvalid toggling (1 of 3 cycles) with rlast on beat 4 -> correct assembly, no extra beats accepted.
- rst asserted in RDATA after beat 2 -> next cycle req_ready=1, all AXI valids 0; a new request completes normally.
- With AXI_TIMEOUT_EN, slave never asserts rvalid -> resp_valid with resp_err=1 after 65535 idle cycles.

Source files
------------

// File: rtl/axi_line_pkg.sv
// Shared types and fixed AXI field values for the cache-line transfer engine.
// Included by axi_line_engine; no configuration lives here.
package axi_line_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RESP
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [3:0] CACHE         = 4'b0011;
    localparam logic [2:0] PROT          = 3'b000;
    localparam logic [3:0] QOS           = 4'b0000;

    // AxSIZE encodes bytes per beat as log2.
    function automatic logic [2:0] axsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_line_engine.sv
// Cache-line engine: optional writeback burst, then line fill, then one-cycle response.
// Optional watchdog on stalled bursts when AXI_TIMEOUT_EN is defined.
module axi_line_engine
    import axi_line_pkg::*;
#(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4,
    localparam int LINE_W = DATA_W * BEATS
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [ADDR_W-1:0] req_fill_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic [3:0]        m_axi_awqos,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,

    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,

    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              aw_done_q, w_done_q, err_q;
    logic [ADDR_W-1:0] wb_addr_q, fill_addr_q;
    logic [LINE_W-1:0] wline_q;
    logic              last_beat, aw_hs, w_hs, timeout;

    assign last_beat = (cnt_q == LAST);
    assign aw_hs     = m_axi_awvalid && m_axi_awready;
    assign w_hs      = m_axi_wvalid && m_axi_wready;
    assign busy      = (state_q != S_IDLE);

    assign m_axi_awaddr  = wb_addr_q;
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = axsize(DATA_W);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awcache = CACHE;
    assign m_axi_awprot  = PROT;
    assign m_axi_awqos   = QOS;
    assign m_axi_wdata   = wline_q[int'(cnt_q)*DATA_W +: DATA_W];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = last_beat;

    assign m_axi_araddr  = fill_addr_q;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = axsize(DATA_W);
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arcache = CACHE;
    assign m_axi_arprot  = PROT;
    assign m_axi_arqos   = QOS;

`ifdef AXI_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        watching, progress;

    assign watching = (state_q == S_WRESP) || (state_q == S_RDATA);
    assign progress = ((state_q == S_WRESP) && m_axi_bvalid) ||
                      ((state_q == S_RDATA) && m_axi_rvalid);
    assign timeout  = watching && !progress && (wd_q == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (rst || !watching || progress)
            wd_q <= '0;
        else if (wd_q != 16'hFFFF)
            wd_q <= wd_q + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = req_wb ? S_WADDR : S_RADDR;
            end
            S_WADDR: begin
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                if ((aw_done_q || aw_hs) &&
                    (w_done_q || (w_hs && last_beat)))
                    state_d = S_WRESP;
            end
            S_WRESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid)
                    state_d = S_RADDR;
                else if (timeout)
                    state_d = S_RESP;
            end
            S_RADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready)
                    state_d = S_RDATA;
            end
            S_RDATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && (m_axi_rlast || last_beat))
                    state_d = S_RESP;
                else if (timeout)
                    state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
            wb_addr_q   <= '0;
            fill_addr_q <= '0;
            wline_q     <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            state_q    <= state_d;
            resp_valid <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wb_addr_q   <= req_wb_addr;
                        fill_addr_q <= req_fill_addr;
                        wline_q     <= req_wdata;
                        err_q       <= 1'b0;
                        cnt_q       <= '0;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                    end
                end
                S_WADDR: begin
                    if (aw_hs)
                        aw_done_q <= 1'b1;
                    if (w_hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat)
                            w_done_q <= 1'b1;
                    end
                end
                S_WRESP: begin
                    if (m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY))
                        err_q <= 1'b1;
                end
                S_RADDR: cnt_q <= '0;
                S_RDATA: begin
                    if (m_axi_rvalid) begin
                        resp_rdata[int'(cnt_q)*DATA_W +: DATA_W] <= m_axi_rdata;
                        cnt_q <= cnt_q + 1'b1;
                        // A burst that ends early or overruns is still reported.
                        if ((m_axi_rresp != AXI_RESP_OKAY) ||
                            (m_axi_rlast != last_beat))
                            err_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                end
                default: ;
            endcase
            if (timeout)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_line_engine.sv
// Self-checking bench for axi_line_engine with a reactive AXI slave model.
// Define AXI_TIMEOUT_EN for both DUT and bench to exercise the watchdog.
module tb_axi_line_engine;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;
    localparam int LINE_W = DATA_W * BEATS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0, req_ready, req_wb = 1'b0;
    logic [ADDR_W-1:0] req_wb_addr = '0, req_fill_addr = '0;
    logic [LINE_W-1:0] req_wdata = '0;
    logic              resp_valid, resp_err, busy;
    logic [LINE_W-1:0] resp_rdata;

    logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]        m_axi_awlen, m_axi_arlen;
    logic [2:0]        m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]        m_axi_awburst, m_axi_arburst;
    logic [3:0]        m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
    logic              m_axi_awvalid, m_axi_awready = 1'b0;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic              m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b0;
    logic [1:0]        m_axi_bresp = 2'b00;
    logic              m_axi_bvalid = 1'b0, m_axi_bready;
    logic              m_axi_arvalid, m_axi_arready = 1'b0;
    logic [DATA_W-1:0] m_axi_rdata = '0;
    logic [1:0]        m_axi_rresp = 2'b00;
    logic              m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;

    axi_line_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int passed = 0;
    int total  = 0;

    logic [LINE_W-1:0] exp_line_q[$];
    logic              exp_err_q[$];
    logic [LINE_W-1:0] model_line = '0;

    // slave configuration
    int          aw_delay  = 0;
    int          r_period  = 1;
    int          rlast_at  = BEATS - 1;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    bit          r_never   = 1'b0;
    logic [DATA_W-1:0] r_data [BEATS];

    // slave observation log
    int cyc = 0, aw_wait = 0, w_idx = 0, r_idx = 0, r_phase = 0;
    int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
    int b_cyc = -1, ar_cyc = -1;
    bit b_pend = 0, r_active = 0, aw_got = 0, w_got = 0;
    logic [ADDR_W-1:0] aw_addr_log = '0, ar_addr_log = '0;
    logic [7:0]        awlen_log = '0, arlen_log = '0;
    logic [LINE_W-1:0] w_line_log = '0;
    logic [BEATS-1:0]  wlast_mask = '0;

    // Slave drives on the falling edge, then logs what the next rising edge will transfer.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
            b_pend = 0; r_active = 0; aw_got = 0; w_got = 0;
            r_idx = 0; r_phase = 0; aw_wait = 0;
        end else begin
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            m_axi_wready  = 1'b1;
            m_axi_bvalid  = b_pend;
            m_axi_bresp   = bresp_cfg;
            m_axi_arready = 1'b1;
            m_axi_rvalid  = r_active && !r_never && (r_phase == r_period - 1);
            m_axi_rdata   = (r_idx < BEATS) ? r_data[r_idx] : '0;
            m_axi_rlast   = (r_idx == rlast_at);
            m_axi_rresp   = rresp_cfg;
            #1;
            if (m_axi_awvalid && !m_axi_awready) aw_wait++;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log = m_axi_awaddr; awlen_log = m_axi_awlen;
                aw_hs_n++; aw_got = 1; aw_wait = 0;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_idx < BEATS) begin
                    w_line_log[w_idx*DATA_W +: DATA_W] = m_axi_wdata;
                    wlast_mask[w_idx] = m_axi_wlast;
                end
                if (m_axi_wlast) w_got = 1;
                w_idx++; w_hs_n++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend = 0; b_cyc = cyc;
            end
            if (aw_got && w_got) begin
                b_pend = 1; aw_got = 0; w_got = 0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_log = m_axi_araddr; arlen_log = m_axi_arlen;
                ar_hs_n++; ar_cyc = cyc;
                r_active = 1; r_idx = 0; r_phase = 0;
            end else if (r_active) begin
                if (m_axi_rvalid && m_axi_rready) begin
                    r_hs_n++;
                    if (m_axi_rlast || r_idx == BEATS - 1) r_active = 0;
                    r_idx++; r_phase = 0;
                end else begin
                    r_phase = (r_phase + 1) % r_period;
                end
            end
        end
    end

    task automatic set_rdata(input logic [DATA_W-1:0] base);
        for (int i = 0; i < BEATS; i++) r_data[i] = base + DATA_W'(i);
    endtask

    task automatic issue_req(input bit wb, input logic [ADDR_W-1:0] wa,
                             input logic [ADDR_W-1:0] fa,
                             input logic [LINE_W-1:0] wd);
        int n = 0;
        @(posedge clk); #2;
        w_idx = 0; wlast_mask = '0; w_line_log = '0;
        aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
        b_cyc = -1; ar_cyc = -1;
        req_valid = 1; req_wb = wb; req_wb_addr = wa;
        req_fill_addr = fa; req_wdata = wd;
        while (!req_ready && n < 50) begin
            @(posedge clk); #2; n++;
        end
        total++;
        if (!req_ready) $display("FAIL req_accept req_ready=%b required 1", req_ready);
        else passed++;
        @(posedge clk); #2;
        req_valid = 0;
    endtask

    task automatic wait_resp(input int limit, output bit got,
                             output logic [LINE_W-1:0] el, output logic ee);
        got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(posedge clk); #1;
            if (resp_valid) got = 1;
        end
        el = exp_line_q.size() ? exp_line_q.pop_front() : 'x;
        ee = exp_err_q.size() ? exp_err_q.pop_front() : 1'bx;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
        total++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got %b want 0", resp_err); else passed++;
        total++; if (resp_rdata !== '0) $display("FAIL rst_rdata got %h want 0", resp_rdata); else passed++;
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0)
            $display("FAIL rst_axi_valids got %b want 00000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        else passed++;
        #2 rst = 0;
    endtask

    task automatic test_fill;
        bit got; logic [LINE_W-1:0] el; logic ee;
        for (int i = 0; i < BEATS; i++) r_data[i] = DATA_W'(32'hA + i);
        model_line = {128'hD, 128'hC, 128'hB, 128'hA};
        exp_line_q.push_back(model_line); exp_err_q.push_back(1'b0);
        issue_req(0, '0, 27'h0000100, '0);
        wait_resp(100, got, el, ee);
        total++; if (!got) $display("FAIL fill_resp timeout resp_valid=0 want 1"); else passed++;
        total++; if (resp_rdata !== el) $display("FAIL fill_data got %h want %h", resp_rdata, el); else passed++;
        total++; if (resp_err !== ee) $display("FAIL fill_err got %b want %b", resp_err, ee); else passed++;
        total++; if (arlen_log !== 8'd3) $display("FAIL fill_arlen got %0d want 3", arlen_log); else passed++;
        total++; if (ar_addr_log !== 27'h100) $display("FAIL fill_araddr got %h want 100", ar_addr_log); else passed++;
        total++; if (aw_hs_n !== 0) $display("FAIL fill_no_aw got %0d want 0", aw_hs_n); else passed++;
        total++; if (r_hs_n !== BEATS) $display("FAIL fill_beats got %0d want %0d", r_hs_n, BEATS); else passed++;
        @(posedge clk); #1;
        total++; if (resp_valid !== 1'b0) $display("FAIL fill_pulse got %b want 0", resp_valid); else passed++;
        total++; if (resp_rdata !== el) $display("FAIL fill_hold got %h want %h", resp_rdata, el); else passed++;
    endtask

    task automatic test_wb_fill(input logic [1:0] bresp, input string tag);
        bit got; logic [LINE_W-1:0] el, wd; logic ee;
        for (int i = 0; i < BEATS; i++) wd[i*DATA_W +: DATA_W] = DATA_W'(32'h5500 + i);
        set_rdata(128'h100);
        for (int i = 0; i < BEATS; i++) model_line[i*DATA_W +: DATA_W] = r_data[i];
        exp_line_q.push_back(model_line); exp_err_q.push_back(bresp != 2'b00);
        aw_delay = 5; bresp_cfg = bresp;
        issue_req(1, 27'h0000200, 27'h0000300, wd);
        wait_resp(200, got, el, ee);
        aw_delay = 0; bresp_cfg = 2'b00;
        total++; if (!got) $display("FAIL %s_resp timeout resp_valid=0 want 1", tag); else passed++;
        total++; if (resp_rdata !== el) $display("FAIL %s_data got %h want %h", tag, resp_rdata, el); else passed++;
        total++; if (resp_err !== ee) $display("FAIL %s_err got %b want %b", tag, resp_err, ee); else passed++;
        total++; if (aw_addr_log !== 27'h200) $display("FAIL %s_awaddr got %h want 200", tag, aw_addr_log); else passed++;
        total++; if (awlen_log !== 8'd3) $display("FAIL %s_awlen got %0d want 3", tag, awlen_log); else passed++;
        total++; if (w_line_log !== wd || w_hs_n !== BEATS)
            $display("FAIL %s_wdata got %h (%0d beats) want %h (%0d beats)", tag, w_line_log, w_hs_n, wd, BEATS);
        else passed++;
        total++; if (wlast_mask !== 4'b1000) $display("FAIL %s_wlast got %b want 1000", tag, wlast_mask); else passed++;
        total++; if (b_cyc < 0 || ar_cyc <= b_cyc)
            $display("FAIL %s_ar_after_b got ar_cyc=%0d b_cyc=%0d want ar after b", tag, ar_cyc, b_cyc);
        else passed++;
        total++; if (ar_addr_log !== 27'h300) $display("FAIL %s_araddr got %h want 300", tag, ar_addr_log); else passed++;
    endtask

    task automatic test_rvalid_toggle;
        bit got; logic [LINE_W-1:0] el; logic ee;
        set_rdata(128'hBEEF_0000);
        for (int i = 0; i < BEATS; i++) model_line[i*DATA_W +: DATA_W] = r_data[i];
        exp_line_q.push_back(model_line); exp_err_q.push_back(1'b0);
        r_period = 3;
        issue_req(0, '0, 27'h0000440, '0);
        wait_resp(200, got, el, ee);
        r_period = 1;
        total++; if (!got) $display("FAIL toggle_resp timeout resp_valid=0 want 1"); else passed++;
        total++; if (resp_rdata !== el) $display("FAIL toggle_data got %h want %h", resp_rdata, el); else passed++;
        total++; if (resp_err !== ee) $display("FAIL toggle_err got %b want %b", resp_err, ee); else passed++;
        total++; if (r_hs_n !== BEATS) $display("FAIL toggle_beats got %0d want %0d", r_hs_n, BEATS); else passed++;
    endtask

    task automatic test_rlast_mismatch;
        bit got; logic [LINE_W-1:0] el; logic ee;
        // early rlast: only the first two slots are replaced
        set_rdata(128'h7700);
        for (int i = 0; i < 2; i++) model_line[i*DATA_W +: DATA_W] = r_data[i];
        exp_line_q.push_back(model_line); exp_err_q.push_back(1'b1);
        rlast_at = 1;
        issue_req(0, '0, 27'h0000500, '0);
        wait_resp(100, got, el, ee);
        total++; if (!got) $display("FAIL early_resp timeout resp_valid=0 want 1"); else passed++;
        total++; if (resp_rdata !== el) $display("FAIL early_data got %h want %h", resp_rdata, el); else passed++;
        total++; if (resp_err !== ee) $display("FAIL early_err got %b want %b", resp_err, ee); else passed++;
        // missing rlast: full line, flagged
        set_rdata(128'h8800);
        for (int i = 0; i < BEATS; i++) model_line[i*DATA_W +: DATA_W] = r_data[i];
        exp_line_q.push_back(model_line); exp_err_q.push_back(1'b1);
        rlast_at = 99;
        issue_req(0, '0, 27'h0000540, '0);
        wait_resp(100, got, el, ee);
        rlast_at = BEATS - 1;
        total++; if (!got) $display("FAIL late_resp timeout resp_valid=0 want 1"); else passed++;
        total++; if (resp_rdata !== el) $display("FAIL late_data got %h want %h", resp_rdata, el); else passed++;
        total++; if (resp_err !== ee) $display("FAIL late_err got %b want %b", resp_err, ee); else passed++;
    endtask

    task automatic test_reset_mid;
        bit got; logic [LINE_W-1:0] el; logic ee;
        int n = 0;
        set_rdata(128'h9900);
        r_period = 3;
        issue_req(0, '0, 27'h0000600, '0);
        while (r_hs_n < 2 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        total++; if (r_hs_n !== 2) $display("FAIL mid_beats2 got %0d want 2", r_hs_n); else passed++;
        rst = 1;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) $display("FAIL mid_req_ready got %b want 1", req_ready); else passed++;
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, resp_valid} !== 6'b0)
            $display("FAIL mid_valids got %b want 000000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, resp_valid});
        else passed++;
        @(posedge clk); #1;
        rst = 0; r_period = 1;
        model_line = '0;
        set_rdata(128'hAA00);
        for (int i = 0; i < BEATS; i++) model_line[i*DATA_W +: DATA_W] = r_data[i];
        exp_line_q.push_back(model_line); exp_err_q.push_back(1'b0);
        issue_req(0, '0, 27'h0000640, '0);
        wait_resp(100, got, el, ee);
        total++; if (!got) $display("FAIL mid_resp timeout resp_valid=0 want 1"); else passed++;
        total++; if (resp_rdata !== el) $display("FAIL mid_data got %h want %h", resp_rdata, el); else passed++;
        total++; if (resp_err !== ee) $display("FAIL mid_err got %b want %b", resp_err, ee); else passed++;
    endtask

    task automatic test_back_to_back;
        bit got; logic [LINE_W-1:0] el; logic ee;
        for (int k = 0; k < 3; k++) begin
            set_rdata(DATA_W'(32'hC000 + 16 * k));
            for (int i = 0; i < BEATS; i++) model_line[i*DATA_W +: DATA_W] = r_data[i];
            exp_line_q.push_back(model_line); exp_err_q.push_back(k == 1);
            rresp_cfg = (k == 1) ? 2'b10 : 2'b00;
            issue_req(0, '0, ADDR_W'(32'h700 + 64 * k), '0);
            wait_resp(100, got, el, ee);
            total++; if (!got || resp_rdata !== el || resp_err !== ee)
                $display("FAIL b2b_%0d got v=%b err=%b data=%h want v=1 err=%b data=%h",
                         k, got, resp_err, resp_rdata, ee, el);
            else passed++;
        end
        rresp_cfg = 2'b00;
    endtask

`ifdef AXI_TIMEOUT_EN
    task automatic test_timeout;
        bit got; logic [LINE_W-1:0] el; logic ee;
        exp_line_q.push_back(model_line); exp_err_q.push_back(1'b1);
        r_never = 1;
        issue_req(0, '0, 27'h0000800, '0);
        wait_resp(70000, got, el, ee);
        r_never = 0;
        total++; if (!got) $display("FAIL timeout_resp resp_valid=0 want 1"); else passed++;
        total++; if (resp_err !== ee) $display("FAIL timeout_err got %b want %b", resp_err, ee); else passed++;
        total++; if (resp_rdata !== el) $display("FAIL timeout_data got %h want %h", resp_rdata, el); else passed++;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_line = '0;
    endtask
`endif

    initial begin
        set_rdata('0);
        test_reset();
        test_fill();
        test_wb_fill(2'b00, "wb");
        test_wb_fill(2'b10, "slverr");
        test_rvalid_toggle();
        test_rlast_mismatch();
        test_reset_mid();
        test_back_to_back();
`ifdef AXI_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
